// File: rtl/view_display.sv
// -----------------------------------------------------------------------------
// view_display
//   Board-side consumer of the CPU's 32-bit `view` debug bus. The latched
//   value is scanned as 8 hex digits onto a multiplexed common-anode
//   7-segment display. A new value is taken only at a frame boundary, which
//   is the wrap from digit 7 back to digit 0. Because of this, one frame never
//   mixes old and new digits.
//
// Parameters
//   SCAN_DIV      clock cycles spent on each digit slot (>= 1)
//   AN_ACTIVE_LOW 1 = anode enables active-low, 0 = active-high
//
// Ports
//   slow_clk  in   sole clock
//   reset     in   asynchronous, active-low reset
//   view      in   [31:0] value to display; digit k shows view[4k+3:4k]
//   freeze    in   1 = hold the currently latched value
//   an        out  [7:0] one-hot digit enable (polarity per AN_ACTIVE_LOW)
//   seg       out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp        out  decimal point, active-low (always off)
//   changed   out  one-cycle pulse when the latched value changes
//
// Optional feature
//   VIEW_DISPLAY_LZB_EN  leading-zero blanking. Digits above the most
//   significant nonzero nibble are blanked. Their anode is still driven, so
//   the scan timing does not change. Digit 0 is never blanked.
// -----------------------------------------------------------------------------
module view_display #(
  parameter int SCAN_DIV      = 50000,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic        slow_clk,
  input  logic        reset,
  input  logic [31:0] view,
  input  logic        freeze,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        changed
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [7:0]    AN_OFF        = AN_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [PW-1:0] prescaler_reg, prescaler_next;
  logic [2:0]    idx_reg, idx_next;
  logic [31:0]   shadow_reg;
  logic          load_pending_reg;

  logic          tick;
  logic          wrap;
  logic          load;

  logic [3:0]    nibble   [8];
  logic [7:0]    nonzero;
  logic [3:0]    cur_nibble;
  logic          blank;
  logic [6:0]    seg_next;
  logic [7:0]    an_next;

  assign tick = (prescaler_reg == PRESCALE_LAST);
  assign wrap = tick && (idx_reg == 3'd7);
  // Loads happen at a frame wrap, or at the first opportunity after reset.
  // A load never happens while freeze is held.
  assign load = (wrap || load_pending_reg) && !freeze;

  assign prescaler_next = tick ? '0 : prescaler_reg + 1'b1;
  assign idx_next       = tick ? idx_reg + 3'd1 : idx_reg;

  // Split the shadow value into digits and note which digits are nonzero.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_nibble
      assign nibble[gi]  = shadow_reg[4*gi +: 4];
      assign nonzero[gi] = |shadow_reg[4*gi +: 4];
    end
  endgenerate

  assign cur_nibble = nibble[idx_reg];

`ifdef VIEW_DISPLAY_LZB_EN
  logic [2:0] msd;
  // The most significant nonzero digit defaults to 0. This keeps digit 0
  // visible when the value is all zeros.
  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (nonzero[i]) msd = 3'(i);
    end
  end
  assign blank = (idx_reg > msd);
`else
  assign blank = 1'b0;
  logic unused_nonzero;
  assign unused_nonzero = ^nonzero;
`endif

  always_comb begin
    seg_next = 7'h7F;
    case (cur_nibble)
      4'h0: seg_next = 7'b1000000;
      4'h1: seg_next = 7'b1111001;
      4'h2: seg_next = 7'b0100100;
      4'h3: seg_next = 7'b0110000;
      4'h4: seg_next = 7'b0011001;
      4'h5: seg_next = 7'b0010010;
      4'h6: seg_next = 7'b0000010;
      4'h7: seg_next = 7'b1111000;
      4'h8: seg_next = 7'b0000000;
      4'h9: seg_next = 7'b0010000;
      4'hA: seg_next = 7'b0001000;
      4'hB: seg_next = 7'b0000011;
      4'hC: seg_next = 7'b1000110;
      4'hD: seg_next = 7'b0100001;
      4'hE: seg_next = 7'b0000110;
      4'hF: seg_next = 7'b0001110;
      default: seg_next = 7'h7F;
    endcase
    if (blank) seg_next = 7'h7F;
  end

  always_comb begin
    an_next = 8'h00;
    an_next[idx_reg] = 1'b1;
    if (AN_ACTIVE_LOW) an_next = ~an_next;
  end

  // Scan counters and the latched value.
  always_ff @(posedge slow_clk or negedge reset) begin
    if (!reset) begin
      prescaler_reg    <= '0;
      idx_reg          <= 3'd0;
      shadow_reg       <= 32'h0;
      load_pending_reg <= 1'b1;
      changed          <= 1'b0;
    end else begin
      prescaler_reg <= prescaler_next;
      idx_reg       <= idx_next;
      changed       <= load && (view != shadow_reg);
      if (load) begin
        shadow_reg       <= view;
        load_pending_reg <= 1'b0;
      end
    end
  end

  // The display outputs are registered from the current idx and shadow,
  // so they lag idx by one cycle.
  always_ff @(posedge slow_clk or negedge reset) begin
    if (!reset) begin
      an  <= AN_OFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= 1'b1;
    end
  end

endmodule
